// File: rtl/chip8_mem_arb.sv
// chip8_mem_arb: shares the CHIP-8 program memory between the instruction
// fetch port and the draw-engine read port, and hosts the UART program
// loader that streams a ROM image into memory starting at LOAD_BASE.
// Build option: define MEM_ARB_LOADER_EN to include the loader. Without it
// the block is a pure read arbiter; the loader inputs are ignored and every
// loader-related output is tied low.
module chip8_mem_arb #(
    parameter int ADDR_WIDTH   = 12,
    parameter int DATA_WIDTH   = 8,
    parameter int LOAD_BASE    = 512,
    parameter int IDLE_TIMEOUT = 1024,
    parameter int STARVE_MAX   = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  f_req,
    input  logic [ADDR_WIDTH-1:0] f_addr,
    output logic                  f_gnt,
    output logic                  f_q_v,
    input  logic                  d_req,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    output logic                  d_gnt,
    output logic                  d_q_v,
    output logic [DATA_WIDTH-1:0] q,
    input  logic [DATA_WIDTH-1:0] ld_d,
    input  logic                  ld_v,
    output logic                  mem_re,
    output logic [ADDR_WIDTH-1:0] mem_raddr,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_waddr,
    output logic [DATA_WIDTH-1:0] mem_d,
    input  logic [DATA_WIDTH-1:0] mem_q,
    output logic                  cpu_hold,
    output logic                  cpu_rst,
    output logic                  ld_ovf
);

`ifdef MEM_ARB_LOADER_EN
    localparam bit LOADER_EN = 1'b1;
`else
    localparam bit LOADER_EN = 1'b0;
`endif

    localparam int IDLE_W   = $clog2(IDLE_TIMEOUT + 1);
    localparam int STARVE_W = $clog2(STARVE_MAX + 1);

    localparam logic [ADDR_WIDTH-1:0] TOP_ADDR     = '1;
    localparam logic [ADDR_WIDTH-1:0] BASE_ADDR    = ADDR_WIDTH'(LOAD_BASE);
    localparam logic [IDLE_W-1:0]     IDLE_LAST    = IDLE_W'(IDLE_TIMEOUT - 1);
    localparam logic [STARVE_W-1:0]   STARVE_LIMIT = STARVE_W'(STARVE_MAX);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                state, state_nx;
    logic [ADDR_WIDTH-1:0] wr_ptr, wr_ptr_nx;
    logic                  ptr_full, ptr_full_nx;
    logic                  ovf, ovf_nx;
    logic [IDLE_W-1:0]     idle_cnt, idle_cnt_nx;
    logic [STARVE_W-1:0]   starve_cnt, starve_nx;
    logic                  f_q_v_r, d_q_v_r;

    logic                  grant_f, grant_d;
    logic                  we_c;
    logic [ADDR_WIDTH-1:0] waddr_c;
    logic                  hold_c, crst_c;

    // Next state, read arbitration, loader write decode and starvation
    // tracking. The write pointer carries a separate "full" flag so a write
    // to the top address can happen without the pointer ever wrapping.
    always_comb begin
        state_nx    = state;
        wr_ptr_nx   = wr_ptr;
        ptr_full_nx = ptr_full;
        ovf_nx      = ovf;
        idle_cnt_nx = idle_cnt;
        grant_f     = 1'b0;
        grant_d     = 1'b0;
        we_c        = 1'b0;
        waddr_c     = wr_ptr;
        hold_c      = 1'b0;
        crst_c      = 1'b0;
        starve_nx   = '0;

        case (state)
            ST_RUN: begin
                idle_cnt_nx = '0;
                if (d_req && !(f_req && (starve_cnt == STARVE_LIMIT))) begin
                    grant_d = 1'b1;
                end else if (f_req) begin
                    grant_f = 1'b1;
                end
                if (LOADER_EN && ld_v) begin
                    state_nx    = ST_LOAD;
                    we_c        = 1'b1;
                    waddr_c     = BASE_ADDR;
                    ovf_nx      = 1'b0;
                    ptr_full_nx = (BASE_ADDR == TOP_ADDR);
                    wr_ptr_nx   = (BASE_ADDR == TOP_ADDR) ? BASE_ADDR
                                                          : BASE_ADDR + 1'b1;
                end
            end
            ST_LOAD: begin
                hold_c = 1'b1;
                if (ld_v) begin
                    idle_cnt_nx = '0;
                    if (ptr_full) begin
                        ovf_nx = 1'b1;
                    end else begin
                        we_c    = 1'b1;
                        waddr_c = wr_ptr;
                        if (wr_ptr == TOP_ADDR) begin
                            ptr_full_nx = 1'b1;
                        end else begin
                            wr_ptr_nx = wr_ptr + 1'b1;
                        end
                    end
                end else if (idle_cnt == IDLE_LAST) begin
                    state_nx = ST_DONE;
                end else begin
                    idle_cnt_nx = idle_cnt + 1'b1;
                end
            end
            ST_DONE: begin
                hold_c      = 1'b1;
                crst_c      = 1'b1;
                idle_cnt_nx = '0;
                state_nx    = ST_RUN;
            end
            default: begin
                state_nx = ST_RUN;
            end
        endcase

        if (f_req && !grant_f) begin
            starve_nx = (starve_cnt == STARVE_LIMIT) ? starve_cnt
                                                     : starve_cnt + 1'b1;
        end
    end

    // State, loader and pipeline registers; the read-valid flags are a
    // one-cycle delay of the grants so they line up with mem_q.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_RUN;
            wr_ptr     <= BASE_ADDR;
            ptr_full   <= 1'b0;
            ovf        <= 1'b0;
            idle_cnt   <= '0;
            starve_cnt <= '0;
            f_q_v_r    <= 1'b0;
            d_q_v_r    <= 1'b0;
        end else begin
            state      <= state_nx;
            wr_ptr     <= wr_ptr_nx;
            ptr_full   <= ptr_full_nx;
            ovf        <= ovf_nx;
            idle_cnt   <= idle_cnt_nx;
            starve_cnt <= starve_nx;
            f_q_v_r    <= grant_f;
            d_q_v_r    <= grant_d;
        end
    end

    assign f_gnt     = grant_f;
    assign d_gnt     = grant_d;
    assign f_q_v     = f_q_v_r;
    assign d_q_v     = d_q_v_r;
    assign q         = mem_q;
    assign mem_re    = grant_f | grant_d;
    assign mem_raddr = grant_d ? d_addr : f_addr;
    assign mem_we    = LOADER_EN & we_c;
    assign mem_waddr = LOADER_EN ? waddr_c : '0;
    assign mem_d     = LOADER_EN ? ld_d : '0;
    assign cpu_hold  = LOADER_EN & hold_c;
    assign cpu_rst   = LOADER_EN & crst_c;
    assign ld_ovf    = LOADER_EN & ovf;

endmodule

// File: tb/tb_chip8_mem_arb.sv
// tb_chip8_mem_arb: self-checking bench for chip8_mem_arb. A behavioural
// memory sits on the memory port; a cycle-level reference model predicts
// every output. Loader sequences are built when MEM_ARB_LOADER_EN is defined.
module tb_chip8_mem_arb;

    localparam int ADDR_WIDTH   = 12;
    localparam int DATA_WIDTH   = 8;
    localparam int LOAD_BASE    = 512;
    localparam int IDLE_TIMEOUT = 1024;
    localparam int STARVE_MAX   = 15;
    localparam int TOP          = (1 << ADDR_WIDTH) - 1;
`ifdef MEM_ARB_LOADER_EN
    localparam bit LOADER = 1'b1;
`else
    localparam bit LOADER = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic f_req, d_req, ld_v;
    logic [11:0] f_addr, d_addr;
    logic [7:0]  ld_d;
    logic f_gnt, f_q_v, d_gnt, d_q_v;
    logic [7:0]  q, mem_d;
    logic [7:0]  mem_q = 8'h00;
    logic mem_re, mem_we, cpu_hold, cpu_rst, ld_ovf;
    logic [11:0] mem_raddr, mem_waddr;

    chip8_mem_arb #(
        .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .LOAD_BASE(LOAD_BASE),
        .IDLE_TIMEOUT(IDLE_TIMEOUT), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk(clk), .rst(rst),
        .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_q_v(f_q_v),
        .d_req(d_req), .d_addr(d_addr), .d_gnt(d_gnt), .d_q_v(d_q_v),
        .q(q), .ld_d(ld_d), .ld_v(ld_v),
        .mem_re(mem_re), .mem_raddr(mem_raddr), .mem_we(mem_we),
        .mem_waddr(mem_waddr), .mem_d(mem_d), .mem_q(mem_q),
        .cpu_hold(cpu_hold), .cpu_rst(cpu_rst), .ld_ovf(ld_ovf)
    );

    always #5 clk = ~clk;

    // Environment memory driven by the DUT's memory port (one-cycle read).
    logic [7:0] mem [0:4095];
    always @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_d;
        if (mem_re) mem_q <= mem[mem_raddr];
    end

    int checks = 0;
    int failures = 0;

    // Reference model state, in terms of the behaviour rather than the RTL.
    logic [7:0] ref_mem [0:4095];
    bit  m_loading, m_done_pulse, m_ovf, m_fv, m_dv;
    int  m_next_addr, m_idle, m_starve;
    logic [7:0] m_q;
    // Expectations for the cycle currently being driven.
    bit  e_f, e_d, e_we, e_hold, e_crst;
    logic [11:0] e_raddr, e_waddr;
    logic [7:0]  e_wd;

    typedef struct {
        logic fr; logic [11:0] fa; logic dr; logic [11:0] da;
        logic ef; logic ed; logic [11:0] eraddr;
    } vec_t;
    vec_t vecs [8];

    function automatic logic [7:0] init_byte(input int a);
        return (a == 'h200) ? 8'h6A : 8'((a * 37 + 11) & 255);
    endfunction

    function automatic logic [7:0] big_byte(input int i);
        return 8'(i & 255) ^ 8'h5A;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        m_loading = 0; m_done_pulse = 0; m_ovf = 0; m_fv = 0; m_dv = 0;
        m_next_addr = LOAD_BASE; m_idle = 0; m_starve = 0; m_q = 8'h00;
    endtask

    // Drive one cycle's inputs and predict that cycle's outputs.
    task automatic applyStimulus(input logic fr, input logic [11:0] fa, input logic dr,
                                 input logic [11:0] da, input logic lv, input logic [7:0] ld);
        bit in_run;
        f_req = fr; f_addr = fa; d_req = dr; d_addr = da; ld_v = lv; ld_d = ld;
        in_run  = !m_loading && !m_done_pulse;
        e_d     = in_run && dr && !(fr && m_starve >= STARVE_MAX);
        e_f     = in_run && fr && !e_d;
        e_raddr = e_d ? da : fa;
        e_we = 0; e_waddr = 12'h000; e_wd = 8'h00;
        if (LOADER && in_run && lv) begin
            e_we = 1; e_waddr = 12'(LOAD_BASE); e_wd = ld;
        end else if (LOADER && m_loading && lv && m_next_addr <= TOP) begin
            e_we = 1; e_waddr = 12'(m_next_addr); e_wd = ld;
        end
        e_hold = LOADER && (m_loading || m_done_pulse);
        e_crst = LOADER && m_done_pulse;
    endtask

    // Compare the DUT against the model, away from the clock edge.
    task automatic checkOutput();
        @(negedge clk);
        check("f_gnt", f_gnt, e_f);
        check("d_gnt", d_gnt, e_d);
        check("mem_re", mem_re, e_f || e_d);
        if (e_f || e_d) check("mem_raddr", mem_raddr, e_raddr);
        check("f_q_v", f_q_v, m_fv);
        check("d_q_v", d_q_v, m_dv);
        if (m_fv || m_dv) check("q", q, m_q);
        check("mem_we", mem_we, e_we);
        if (e_we) begin
            check("mem_waddr", mem_waddr, e_waddr);
            check("mem_d", mem_d, e_wd);
        end
`ifndef MEM_ARB_LOADER_EN
        check("mem_waddr_tied", mem_waddr, 12'h000);
        check("mem_d_tied", mem_d, 8'h00);
`endif
        check("cpu_hold", cpu_hold, e_hold);
        check("cpu_rst", cpu_rst, e_crst);
        check("ld_ovf", ld_ovf, m_ovf);
    endtask

    // Cross the active edge and advance the model by one cycle.
    task automatic endCycle();
        @(posedge clk);
        #1;
        m_fv = e_f; m_dv = e_d;
        if (e_f || e_d) m_q = ref_mem[e_raddr];
        if (e_we) ref_mem[e_waddr] = e_wd;
        if (f_req && !e_f) m_starve = (m_starve < STARVE_MAX) ? m_starve + 1 : STARVE_MAX;
        else m_starve = 0;
        if (LOADER) begin
            if (m_done_pulse) begin
                m_done_pulse = 0;
            end else if (!m_loading) begin
                if (ld_v) begin
                    m_loading = 1; m_next_addr = LOAD_BASE + 1; m_idle = 0; m_ovf = 0;
                end
            end else if (ld_v) begin
                m_idle = 0;
                if (m_next_addr > TOP) m_ovf = 1;
                else m_next_addr++;
            end else if (m_idle == IDLE_TIMEOUT - 1) begin
                m_loading = 0; m_done_pulse = 1;
            end else begin
                m_idle++;
            end
        end
    endtask

    task automatic step(input logic fr, input logic [11:0] fa, input logic dr,
                        input logic [11:0] da, input logic lv, input logic [7:0] ld);
        applyStimulus(fr, fa, dr, da, lv, ld);
        checkOutput();
        endCycle();
    endtask

    task automatic resetDut();
        rst = 1'b1; f_req = 0; d_req = 0; ld_v = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        modelReset();
        applyStimulus(0, 12'h000, 0, 12'h000, 0, 8'h00);
        checkOutput();
        check("rst_f_q_v", f_q_v, 1'b0);
        check("rst_d_q_v", d_q_v, 1'b0);
        check("rst_cpu_hold", cpu_hold, 1'b0);
        check("rst_cpu_rst", cpu_rst, 1'b0);
        check("rst_ld_ovf", ld_ovf, 1'b0);
        check("rst_mem_we", mem_we, 1'b0);
        endCycle();
    endtask

    initial begin
        int first_rst, pulses;
        logic fr, dr, lv;
        rst = 1'b1; f_req = 0; d_req = 0; ld_v = 0;
        f_addr = 0; d_addr = 0; ld_d = 0;
        for (int a = 0; a < 4096; a++) begin
            mem[a] = init_byte(a);
            ref_mem[a] = init_byte(a);
        end
        vecs[0] = '{1'b1, 12'h200, 1'b0, 12'h000, 1'b1, 1'b0, 12'h200};
        vecs[1] = '{1'b0, 12'h000, 1'b1, 12'h300, 1'b0, 1'b1, 12'h300};
        vecs[2] = '{1'b1, 12'h123, 1'b1, 12'h456, 1'b0, 1'b1, 12'h456};
        vecs[3] = '{1'b1, 12'h124, 1'b0, 12'h000, 1'b1, 1'b0, 12'h124};
        vecs[4] = '{1'b0, 12'h000, 1'b0, 12'h000, 1'b0, 1'b0, 12'h000};
        vecs[5] = '{1'b1, 12'hFFF, 1'b1, 12'h000, 1'b0, 1'b1, 12'h000};
        vecs[6] = '{1'b0, 12'h000, 1'b1, 12'hABC, 1'b0, 1'b1, 12'hABC};
        vecs[7] = '{1'b1, 12'h001, 1'b0, 12'h000, 1'b1, 1'b0, 12'h001};

        resetDut();

        // Fixed arbitration vectors from a fresh reset.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].fr, vecs[i].fa, vecs[i].dr, vecs[i].da, 1'b0, 8'h00);
            checkOutput();
            check("tab_f_gnt", f_gnt, vecs[i].ef);
            check("tab_d_gnt", d_gnt, vecs[i].ed);
            if (vecs[i].ef || vecs[i].ed) check("tab_raddr", mem_raddr, vecs[i].eraddr);
            endCycle();
        end

        // Both ports requesting continuously: fetch forced on the 16th cycle.
        resetDut();
        for (int i = 0; i < 17; i++) begin
            applyStimulus(1, 12'(16 + i), 1, 12'(32 + i), 0, 8'h00);
            checkOutput();
            check("starve_d_gnt", d_gnt, (i < 15 || i == 16) ? 1'b1 : 1'b0);
            check("starve_f_gnt", f_gnt, (i == 15) ? 1'b1 : 1'b0);
            endCycle();
        end

        // Single fetch at 0x200 returns 0x6A one cycle later.
        resetDut();
        applyStimulus(1, 12'h200, 0, 12'h000, 0, 8'h00);
        checkOutput();
        check("fetch_gnt", f_gnt, 1'b1);
        endCycle();
        applyStimulus(0, 12'h000, 0, 12'h000, 0, 8'h00);
        checkOutput();
        check("fetch_q_v", f_q_v, 1'b1);
        check("fetch_q", q, 8'h6A);
        check("fetch_no_d_q_v", d_q_v, 1'b0);
        endCycle();

        // Randomised traffic; draw requests dominate so starvation occurs.
        for (int i = 0; i < 600; i++) begin
            fr = ($urandom_range(0, 3) != 0);
            dr = ($urandom_range(0, 9) != 0);
`ifdef MEM_ARB_LOADER_EN
            lv = 1'b0;
`else
            lv = 1'($urandom_range(0, 1));
`endif
            step(fr, 12'($urandom), dr, 12'($urandom), lv, 8'($urandom));
        end

        // Reset right after a grant must suppress the pending valid.
        step(1, 12'h050, 0, 12'h000, 0, 8'h00);
        resetDut();

`ifdef MEM_ARB_LOADER_EN
        // Three-byte load followed by idle timeout.
        applyStimulus(1, 12'h100, 0, 12'h000, 1, 8'h12);
        checkOutput();
        check("ld0_f_gnt", f_gnt, 1'b1);
        check("ld0_we", mem_we, 1'b1);
        check("ld0_waddr", mem_waddr, 12'h200);
        endCycle();
        applyStimulus(1, 12'h100, 0, 12'h000, 1, 8'h34);
        checkOutput();
        check("ld1_hold", cpu_hold, 1'b1);
        check("ld1_f_gnt", f_gnt, 1'b0);
        check("ld1_f_q_v", f_q_v, 1'b1);
        check("ld1_waddr", mem_waddr, 12'h201);
        endCycle();
        step(0, 12'h000, 0, 12'h000, 1, 8'h56);
        first_rst = -1; pulses = 0;
        for (int i = 0; i < IDLE_TIMEOUT + 4; i++) begin
            applyStimulus(1, 12'h010, 0, 12'h000, 0, 8'h00);
            checkOutput();
            if (cpu_rst === 1'b1) begin
                pulses++;
                if (first_rst < 0) first_rst = i;
            end
            endCycle();
        end
        check("done_cycle", first_rst, IDLE_TIMEOUT);
        check("done_pulses", pulses, 1);
        check("mem_200", mem[12'h200], 8'h12);
        check("mem_201", mem[12'h201], 8'h34);
        check("mem_202", mem[12'h202], 8'h56);

        // Overflowing load: 3585 bytes, the last one dropped.
        for (int i = 0; i < 3585; i++) step(0, 12'h000, 0, 12'h000, 1, big_byte(i));
        applyStimulus(0, 12'h000, 0, 12'h000, 0, 8'h00);
        checkOutput();
        check("ovf_set", ld_ovf, 1'b1);
        endCycle();
        for (int i = 0; i < IDLE_TIMEOUT; i++) step(0, 12'h000, 1, 12'h020, 0, 8'h00);
        applyStimulus(0, 12'h000, 0, 12'h000, 0, 8'h00);
        checkOutput();
        check("ovf_sticky", ld_ovf, 1'b1);
        check("ovf_run_hold", cpu_hold, 1'b0);
        endCycle();
        check("mem_fff", mem[12'hFFF], big_byte(3583));
        check("mem_000_nowrap", mem[12'h000], init_byte(0));

        // New load clears overflow; reset after five bytes aborts it.
        step(0, 12'h000, 0, 12'h000, 1, 8'hC1);
        applyStimulus(0, 12'h000, 0, 12'h000, 1, 8'hC2);
        checkOutput();
        check("ovf_cleared", ld_ovf, 1'b0);
        endCycle();
        for (int i = 3; i <= 5; i++) step(0, 12'h000, 0, 12'h000, 1, 8'(8'hC0 + i));
        resetDut();
        for (int i = 0; i < 3; i++) step(1, 12'h040, 0, 12'h000, 0, 8'h00);
        for (int i = 1; i <= 4; i++) check("kept_byte", mem[12'(12'h200 + i)], 8'(8'hC1 + i));
        applyStimulus(0, 12'h000, 0, 12'h000, 1, 8'hEE);
        checkOutput();
        check("reload_we", mem_we, 1'b1);
        check("reload_waddr", mem_waddr, 12'h200);
        endCycle();
        step(0, 12'h000, 0, 12'h000, 0, 8'h00);
`else
        // Loader stream is ignored while fetch is busy.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1, 12'(12'h300 + i), 0, 12'h000, 1'(i % 2), 8'hA5);
            checkOutput();
            check("noload_we", mem_we, 1'b0);
            check("noload_f_gnt", f_gnt, 1'b1);
            endCycle();
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/chip8_mem_arb.md
CHIP8_MEM_ARB -- requirements
Module: chip8_mem_arb

Interface
REQ-001 Parameters (name, default, meaning): ADDR_WIDTH, 12, memory address bits; DATA_WIDTH, 8, byte width; LOAD_BASE, 512, first loader write address; IDLE_TIMEOUT, 1024, idle cycles ending a load; STARVE_MAX, 15, consecutive fetch denials before fetch is forced.
REQ-002 Ports (name, direction, width, meaning):
- clk, in, 1, sole clock.
- rst, in, 1, synchronous active-high reset.
- f_req / f_addr / f_gnt / f_q_v: in 1 / in ADDR_WIDTH / out 1 / out 1; instruction-fetch read port.
- d_req / d_addr / d_gnt / d_q_v: in 1 / in ADDR_WIDTH / out 1 / out 1; draw-engine read port.
- q, out, DATA_WIDTH: read data, wired from mem_q.
- ld_d / ld_v: in DATA_WIDTH / in 1; loader byte stream from UART.
- mem_re / mem_raddr / mem_we / mem_waddr / mem_d: out 1 / out ADDR_WIDTH / out 1 / out ADDR_WIDTH / out DATA_WIDTH; memory side.
- mem_q, in, DATA_WIDTH: memory read data, one-cycle latency.
- cpu_hold, out, 1: high while loading; cpu_rst, out, 1: one-cycle pulse at load end.
- ld_ovf, out, 1: sticky, load exceeded top address.
REQ-003 The block has one clock, clk; reset rst is synchronous and active-high.

Function
REQ-004 States: ST_RUN, ST_LOAD, ST_DONE (one cycle).
REQ-005 ST_RUN: read port arbitration every cycle; combinational grant; mem_re = f_gnt | d_gnt; mem_raddr = address of the granted requester.
REQ-006 Priority: draw beats fetch, except when the starvation counter equals STARVE_MAX; then fetch wins that cycle.
REQ-007 Starvation counter: increments when f_req is high and f_gnt is low; clears on f_gnt or when f_req is low; saturates at STARVE_MAX.
REQ-008 At most one of f_gnt, d_gnt is high in any cycle; a grant requires its req in the same cycle.
REQ-009 Read latency: f_q_v or d_q_v asserts exactly one cycle after the matching grant, while q holds that byte; at most one valid per cycle.
REQ-010 ST_RUN with ld_v high goes to ST_LOAD; that byte is written to LOAD_BASE in the same cycle and the write pointer becomes LOAD_BASE+1.
REQ-011 ST_LOAD: cpu_hold=1; f_gnt=d_gnt=0; mem_re=0. Each ld_v writes ld_d at the pointer (mem_we=1 for one cycle), then the pointer increments.
REQ-012 Top address: a write at 2^ADDR_WIDTH-1 is performed and the pointer stops. Further ld_v bytes are dropped and set ld_ovf; the pointer never wraps.
REQ-013 Idle counter: clears on ld_v and increments otherwise. Reaching IDLE_TIMEOUT-1 with ld_v low goes to ST_DONE. ld_v on the timeout cycle is written and the counter clears.
REQ-014 ST_DONE: cpu_rst=1 and cpu_hold=1 for one cycle; next state ST_RUN; ld_v in ST_DONE is ignored.
REQ-015 Entering ST_LOAD clears ld_ovf. A new ld_v in ST_RUN starts a fresh load at LOAD_BASE.
REQ-016 Read-valid pipeline: the cycle after entering ST_LOAD still emits the valid for a grant issued in the last ST_RUN cycle.

Reset
REQ-017 rst applies in any state, including mid-load.
REQ-018 Reset values: state ST_RUN, all grants and valids 0, mem_we/mem_re 0, cpu_hold 0, cpu_rst 0, ld_ovf 0, pointer LOAD_BASE, both counters 0.
REQ-019 Bytes already written before a mid-load reset stay in memory; no cpu_rst pulse is generated.

Configuration
REQ-020 Macro MEM_ARB_LOADER_EN defined: loader, ST_LOAD/ST_DONE, cpu_hold, cpu_rst and ld_ovf behave as specified.
REQ-021 Macro MEM_ARB_LOADER_EN undefined: the FSM stays in ST_RUN and ld_d/ld_v are ignored. mem_we, cpu_hold, cpu_rst and ld_ovf are tied 0; mem_waddr and mem_d are tied 0. Arbitration is unchanged.

Verification
REQ-022 f_req=1 and d_req=1 held for 16 cycles -> d_gnt for cycles 0-14, f_gnt on cycle 15, counter clears.
REQ-023 Single f_req, f_addr=0x200, mem_q=0x6A next cycle -> f_gnt cycle 0; f_q_v=1 and q=0x6A cycle 1; d_q_v=0.
REQ-024 Loader: bytes 0x12,0x34,0x56 on ld_v, then idle -> writes to 0x200-0x202; ST_DONE after IDLE_TIMEOUT idle cycles; cpu_rst one-cycle pulse; ST_RUN.
REQ-025 Load 3585 bytes starting at 0x200 -> last write at 0xFFF; 3585th byte dropped; ld_ovf=1 until next load.
REQ-026 rst asserted mid-load after 5 bytes -> next cycle ST_RUN, cpu_hold=0, no cpu_rst; next ld_v writes 0x200.
REQ-027 MEM_ARB_LOADER_EN undefined, ld_v pulses during f_req -> mem_we stays 0 and f_gnt is unaffected.
